m2v_sched: RTL and testbench

- Round-robin scheduler that shares one M2V systolic matrix-vector unit (16x16 by 16x1, 8-bit lanes) between two requesters.
- Accepts a vector job from either requester over a valid/ready handshake, then drives the M2V enable and vector for a fixed run window.
- After the window it captures the packed MV result and returns it on a single response channel tagged with the requester id.
- Sits between the layer control logic and the M2V instance. Matrix rows are wired to M2V directly and are outside this block's control.

---
 rtl/m2v_sched.sv | 103 ++++++++++
 tb/tb_m2v_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/m2v_sched.sv
// Round-robin scheduler sharing one M2V matrix-vector unit between two requesters.
// Holds m2v_en for a fixed run window, captures MV, returns it tagged with the requester id.
module m2v_sched #(
  parameter int DIMENSION  = 16,
  parameter int WIDTH      = 8,
  parameter int RUN_CYCLES = 33
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [DIMENSION*WIDTH-1:0] req_vec0,
  input  logic [DIMENSION*WIDTH-1:0] req_vec1,
  input  logic                       abort,
  output logic                       m2v_en,
  output logic [DIMENSION*WIDTH-1:0] m2v_V,
  input  logic [DIMENSION*WIDTH-1:0] m2v_MV,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [DIMENSION*WIDTH-1:0] resp_data,
  output logic                       resp_id,
  output logic                       busy
);

  localparam int CW = $clog2(RUN_CYCLES);

  typedef enum logic [1:0] {IDLE, RUN, CAP, RESP} state_t;

  state_t        state;
  logic          rr_ptr;
  logic [CW-1:0] run_cnt;
  logic [1:0]    grant;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  assign req_ready = (state == IDLE) ? grant : 2'b00;
  assign busy      = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      run_cnt    <= '0;
      m2v_en     <= 1'b0;
      m2v_V      <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            m2v_V   <= grant[1] ? req_vec1 : req_vec0;
            resp_id <= grant[1];
            rr_ptr  <= ~grant[1];
            run_cnt <= '0;
            m2v_en  <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            m2v_en <= 1'b0;
            state  <= IDLE;
          end else if (run_cnt == CW'(RUN_CYCLES - 1)) begin
            // Dropping en here makes M2V freeze MV for the capture cycle.
            m2v_en <= 1'b0;
            state  <= CAP;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        CAP: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            resp_data  <= m2v_MV;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m2v_sched.sv
// Randomised bench for m2v_sched: a cycle-timeline reference model plus an M2V stub,
// with a response scoreboard drained by an independent monitor.
module tb_m2v_sched;

  localparam int DIMENSION = 16;
  localparam int WIDTH     = 8;
  localparam int VW        = DIMENSION * WIDTH;
  localparam int RUN       = 33;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [VW-1:0] req_vec0, req_vec1;
  logic          abort;
  logic          m2v_en;
  logic [VW-1:0] m2v_V;
  logic [VW-1:0] m2v_MV;
  logic          resp_valid;
  logic          resp_ready;
  logic [VW-1:0] resp_data;
  logic          resp_id;
  logic          busy;

  m2v_sched #(.DIMENSION(DIMENSION), .WIDTH(WIDTH), .RUN_CYCLES(RUN)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_vec0(req_vec0), .req_vec1(req_vec1), .abort(abort),
    .m2v_en(m2v_en), .m2v_V(m2v_V), .m2v_MV(m2v_MV),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_id(resp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // M2V stub: yields a result only when en was high for exactly RUN cycles before dropping.
  localparam logic [VW-1:0] FILL_A5 = {DIMENSION{8'hA5}};
  localparam logic [VW-1:0] XMASK   = {DIMENSION{8'h3C}};
  logic stub_const = 1'b0;
  int   en_run = 0;

  always @(posedge clk) en_run <= m2v_en ? en_run + 1 : 0;

  assign m2v_MV = (!m2v_en && en_run == RUN) ? (stub_const ? FILL_A5 : (m2v_V ^ XMASK)) : '0;

  // Reference model: age counts cycles since grant (-1 = free); pref is the favoured requester.
  int              mdl_age = -1;
  logic            mdl_pref = 1'b0;
  logic            job_id;
  logic [VW-1:0]   job_vec, job_res;
  logic [VW:0]     sb_q[$];

  function automatic logic [1:0] rr_grant(input logic [1:0] v, input logic pref);
    if (v == 2'b01) return 2'b01;
    if (v == 2'b10) return 2'b10;
    if (v == 2'b11) return pref ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  always @(negedge clk) begin
    logic [1:0] g;
    if (rst) begin
      mdl_age  = -1;
      mdl_pref = 1'b0;
      sb_q.delete();
    end else if (mdl_age < 0) begin
      g = rr_grant(req_valid, mdl_pref);
      check("idle_req_ready", VW'(req_ready), VW'(g));
      check("idle_en", VW'(m2v_en), '0);
      check("idle_resp_valid", VW'(resp_valid), '0);
      check("idle_busy", VW'(busy), '0);
      if (g != 2'b00) begin
        job_id   = g[1];
        job_vec  = g[1] ? req_vec1 : req_vec0;
        job_res  = stub_const ? FILL_A5 : (job_vec ^ XMASK);
        mdl_pref = ~g[1];
        mdl_age  = 1;
      end
    end else if (mdl_age <= RUN) begin
      check("run_en", VW'(m2v_en), VW'(1));
      check("run_vec", m2v_V, job_vec);
      check("run_busy", VW'(busy), VW'(1));
      check("run_req_ready", VW'(req_ready), '0);
      check("run_resp_valid", VW'(resp_valid), '0);
      mdl_age = abort ? -1 : mdl_age + 1;
    end else if (mdl_age == RUN + 1) begin
      check("cap_en", VW'(m2v_en), '0);
      check("cap_busy", VW'(busy), VW'(1));
      check("cap_req_ready", VW'(req_ready), '0);
      check("cap_resp_valid", VW'(resp_valid), '0);
      if (abort) mdl_age = -1;
      else begin
        sb_q.push_back({job_id, job_res});
        mdl_age++;
      end
    end else begin
      check("resp_valid", VW'(resp_valid), VW'(1));
      check("resp_busy", VW'(busy), VW'(1));
      check("resp_en", VW'(m2v_en), '0);
      check("resp_req_ready", VW'(req_ready), '0);
      if (resp_ready) mdl_age = -1;
    end
  end

  // Monitor: every presented response is compared with the scoreboard head.
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (sb_q.size() == 0) begin
        check("resp_unexpected", VW'(resp_valid), '0);
      end else begin
        check("resp_id", VW'(resp_id), VW'(sb_q[0][VW]));
        check("resp_data", resp_data, sb_q[0][VW-1:0]);
        if (resp_ready) void'(sb_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((mdl_age >= 0 || sb_q.size() != 0) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) check("wait_idle_timeout", VW'(1), '0);
  endtask

  task automatic wait_resp();
    int n = 0;
    while (!resp_valid && n < 80) begin
      step();
      n++;
    end
    if (n >= 80) check("wait_resp_timeout", VW'(resp_valid), VW'(1));
  endtask

  function automatic logic [VW-1:0] rand_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [VW-1:0] ramp;
    for (int k = 0; k < DIMENSION; k++) ramp[VW-1-8*k -: 8] = 8'(k + 1);

    rst = 1'b1; req_valid = 2'b00; req_vec0 = '0; req_vec1 = '0;
    abort = 1'b0; resp_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check("reset_V", m2v_V, '0);
    check("reset_data", resp_data, '0);
    check("reset_id", VW'(resp_id), '0);
    step();

    // Contention: both requesters hold valid for four jobs; model enforces 0,1,0,1.
    req_vec0 = rand_vec(); req_vec1 = rand_vec(); req_valid = 2'b11;
    repeat (4 * (RUN + 3)) step();
    req_valid = 2'b00;
    wait_idle();

    // Single job, stub returning 0xA5 in every lane.
    stub_const = 1'b1;
    req_vec0 = ramp; req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    wait_idle();
    stub_const = 1'b0;

    // Back-pressure: response held for 10 cycles.
    resp_ready = 1'b0; req_vec0 = rand_vec(); req_valid = 2'b01;
    step();
    req_valid = 2'b10; req_vec1 = rand_vec();
    wait_resp();
    repeat (10) step();
    req_valid = 2'b00;
    resp_ready = 1'b1;
    step();
    wait_idle();

    // Abort in RUN, then requester 1 granted the next cycle.
    req_vec0 = rand_vec(); req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    repeat (12) step();
    abort = 1'b1;
    step();
    abort = 1'b0; req_vec1 = rand_vec(); req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    wait_idle();

    // Reset mid-run; afterwards requester 0 is preferred again.
    req_vec1 = rand_vec(); req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    repeat (20) step();
    rst = 1'b1;
    step();
    rst = 1'b0; req_vec0 = rand_vec(); req_vec1 = rand_vec(); req_valid = 2'b11;
    @(negedge clk);
    check("rst_mid_V", m2v_V, '0);
    check("rst_mid_data", resp_data, '0);
    check("rst_mid_id", VW'(resp_id), '0);
    check("rst_mid_grant0", VW'(req_ready), VW'(2'b01));
    step();
    req_valid = 2'b00;
    wait_idle();

    // Abort together with resp_ready in RESP completes the response.
    resp_ready = 1'b0; req_vec1 = rand_vec(); req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    wait_resp();
    abort = 1'b1; resp_ready = 1'b1;
    step();
    abort = 1'b0;
    req_vec0 = rand_vec(); req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    wait_idle();

    // Randomised traffic with back-pressure, aborts and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      req_valid  = 2'($urandom);
      req_vec0   = rand_vec();
      req_vec1   = rand_vec();
      resp_ready = ($urandom % 10) < 7;
      abort      = ($urandom % 150) == 0;
      rst        = ($urandom % 800) == 0;
      step();
    end
    rst = 1'b0; abort = 1'b0; req_valid = 2'b00; resp_ready = 1'b1;
    wait_idle();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
